rect_plot_arbiter: RTL and testbench
====================================

RECT_PLOT_ARBITER -- requirements
Module: rect_plot_arbiter

Interface
REQ-001 Parameter NREQ, 3, number of requesters.
REQ-002 Parameter XW, 8, pixel x width; YW, 7, pixel y width; CW, 3, colour width.
REQ-003 Parameter XMAX, 160, screen width; YMAX, 120, screen height; DW, 4, rectangle dimension width.
REQ-004 clk  in  1  clock, all state on rising edge.
REQ-005 resetn  in  1  reset resetn, synchronous, active-low.
REQ-006 req  in  NREQ  per-requester draw request, level.
REQ-007 req_x  in  NREQ*XW  rectangle origin x, packed, requester i at slice i.
REQ-008 req_y  in  NREQ*YW  rectangle origin y, packed.
REQ-009 req_w, req_h  in  NREQ*DW each  rectangle width/height in pixels, 0..15.
REQ-010 req_colour  in  NREQ*CW  fill colour, packed.
REQ-011 gnt  out  NREQ  one-hot, one-cycle pulse: operands of requester i latched.
REQ-012 done  out  NREQ  one-hot, one-cycle pulse: requester i rectangle fully issued.
REQ-013 vga_x / vga_y / vga_colour  out  XW / YW / CW  pixel to the VGA adapter, registered.
REQ-014 vga_we  out  1  pixel write enable, registered.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, ARB, DRAW, DONE.
REQ-017 IDLE: SHALL go to ARB when any req bit is high, else stay.
REQ-018 ARB: SHALL pick the first asserted req at or after index (last_served+1) mod NREQ, pulse gnt[i], latch its x, y, w, h, colour and index.
REQ-019 ARB: SHALL go to DONE if latched w==0 or h==0 (no pixels), else to DRAW.
REQ-020 DRAW: SHALL issue one pixel per cycle in raster order, column counter fastest, from (x,y) to (x+w-1,y+h-1).
REQ-021 A pixel SHALL drive vga_we=1 only when x+col<XMAX and y+row<YMAX; clipped pixels still consume one cycle with vga_we=0.
REQ-022 Coordinate sums SHALL be computed one bit wider than XW/YW so wrap-around never un-clips a pixel.
REQ-023 DRAW SHALL go to DONE in the cycle after the last pixel is presented; total DRAW cycles = w*h.
REQ-024 DONE: SHALL pulse done[i], set last_served=i, clear counters, go to IDLE.
REQ-025 Latency: req rising in IDLE cycle n -> gnt at n+1 -> first vga_we at n+2.
REQ-026 Requesters SHALL hold req and operands stable until gnt; operand changes after gnt SHALL not affect the active rectangle.
REQ-027 A req still high after its done SHALL be treated as a new request.
REQ-028 req changes during ARB-to-DONE SHALL not pre-empt the active rectangle.
REQ-029 gnt and done SHALL never be high in the same cycle for the same index.

Reset
REQ-030 resetn low at any edge, including mid-DRAW, SHALL force IDLE, counters 0, last_served=NREQ-1, gnt=0, done=0, vga_we=0, vga_x=0, vga_y=0, vga_colour=0, busy=0.
REQ-031 A rectangle interrupted by reset SHALL not be resumed and SHALL not produce done.

Structure
REQ-032 State encoding, XMAX/YMAX and the packed-slice width constants SHALL live in the shared game package.
REQ-033 The round-robin selector SHALL be one sub-module, rr_select (req, last_served -> one-hot pick, valid).

Verification
REQ-034 Single req[0], x=10,y=20,w=3,h=2,colour=4 -> gnt[0] at n+1; six vga_we pixels (10,20),(11,20),(12,20),(10,21),(11,21),(12,21) colour 4; done[0] one cycle after the last.
REQ-035 req=3'b111 held with w=h=1 -> grants in order 0,1,2,0 and each gnt followed by exactly one pixel.
REQ-036 req[1] x=158,y=119,w=4,h=2 -> 8 DRAW cycles, vga_we only at (158,119),(159,119), done[1] after cycle 8.
REQ-037 req[2] w=0,h=5 -> gnt[2], no vga_we, done[2] at n+2.
REQ-038 resetn low on the 3rd pixel of a 4x4 rectangle -> next cycle IDLE, all outputs 0, no done; after release a pending req restarts from pixel (0,0) of its rectangle.
REQ-039 Operands of req[0] changed the cycle after gnt[0] -> drawn pixels match the values latched at gnt.

Source files
------------

// File: rtl/rect_plot_arbiter_pkg.sv
// Shared screen limits, bus widths and FSM encoding for the rectangle plot arbiter.
// Every file of the block imports this package.
package rect_plot_arbiter_pkg;

  localparam int unsigned NREQ_DEF    = 3;
  localparam int unsigned XW_DEF      = 8;
  localparam int unsigned YW_DEF      = 7;
  localparam int unsigned CW_DEF      = 3;
  localparam int unsigned DW_DEF      = 4;
  localparam int unsigned SCREEN_XMAX = 160;
  localparam int unsigned SCREEN_YMAX = 120;

  // Widths of the packed per-requester operand buses.
  localparam int unsigned REQ_X_W = NREQ_DEF * XW_DEF;
  localparam int unsigned REQ_Y_W = NREQ_DEF * YW_DEF;
  localparam int unsigned REQ_D_W = NREQ_DEF * DW_DEF;
  localparam int unsigned REQ_C_W = NREQ_DEF * CW_DEF;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StArb  = 2'd1,
    StDraw = 2'd2,
    StDone = 2'd3
  } state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rect_plot_arbiter_rr_select.sv
// Round-robin selector: one-hot pick of the first asserted request strictly after
// the last served index, wrapping modulo NREQ.
module rr_select
  import rect_plot_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned IW   = idx_width(NREQ_DEF)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic [NREQ-1:0] pick_o,
  output logic            valid_o
);

  always_comb begin
    int unsigned j;
    logic        found;
    pick_o = '0;
    found  = 1'b0;
    j      = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      j = (32'(last_i) + k) % NREQ;
      if (!found && req_i[j]) begin
        pick_o[j] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/rect_plot_arbiter.sv
// Arbitrates rectangle fill requests round-robin and rasterises the granted
// rectangle into one clipped VGA pixel write per cycle.
module rect_plot_arbiter
  import rect_plot_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned XW   = XW_DEF,
  parameter int unsigned YW   = YW_DEF,
  parameter int unsigned CW   = CW_DEF,
  parameter int unsigned XMAX = SCREEN_XMAX,
  parameter int unsigned YMAX = SCREEN_YMAX,
  parameter int unsigned DW   = DW_DEF
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ*XW-1:0]   req_x_i,
  input  logic [NREQ*YW-1:0]   req_y_i,
  input  logic [NREQ*DW-1:0]   req_w_i,
  input  logic [NREQ*DW-1:0]   req_h_i,
  input  logic [NREQ*CW-1:0]   req_colour_i,
  output logic [NREQ-1:0]      gnt_o,
  output logic [NREQ-1:0]      done_o,
  output logic [XW-1:0]        vga_x_o,
  output logic [YW-1:0]        vga_y_o,
  output logic [CW-1:0]        vga_colour_o,
  output logic                 vga_we_o,
  output logic                 busy_o
);

  localparam int unsigned IW  = idx_width(NREQ);
  localparam int unsigned XSW = XW + 1;
  localparam int unsigned YSW = YW + 1;

  state_e          state_q;
  logic [IW-1:0]   last_q, idx_q;
  logic [NREQ-1:0] sel_q, gnt_q, done_q;
  logic [XW-1:0]   x_q, vga_x_q;
  logic [YW-1:0]   y_q, vga_y_q;
  logic [DW-1:0]   w_q, h_q, col_q, row_q;
  logic [CW-1:0]   colour_q, vga_colour_q;
  logic            vga_we_q;

  logic [NREQ-1:0] pick;
  logic            pick_valid;

  rr_select #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_select (
    .req_i   (req_i),
    .last_i  (last_q),
    .pick_o  (pick),
    .valid_o (pick_valid)
  );

  logic [IW-1:0] pick_idx;
  logic [XW-1:0] sel_x;
  logic [YW-1:0] sel_y;
  logic [DW-1:0] sel_w, sel_h;
  logic [CW-1:0] sel_c;

  always_comb begin
    pick_idx = '0;
    sel_x    = '0;
    sel_y    = '0;
    sel_w    = '0;
    sel_h    = '0;
    sel_c    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick[i]) begin
        pick_idx = IW'(i);
        sel_x    = req_x_i[i*XW +: XW];
        sel_y    = req_y_i[i*YW +: YW];
        sel_w    = req_w_i[i*DW +: DW];
        sel_h    = req_h_i[i*DW +: DW];
        sel_c    = req_colour_i[i*CW +: CW];
      end
    end
  end

  // Pixel to present next; sums are one bit wider so a wrapped origin stays clipped.
  logic [DW-1:0]  col_n, row_n;
  logic           last_px, px_on;
  logic [XSW-1:0] sum_x;
  logic [YSW-1:0] sum_y;

  always_comb begin
    last_px = (col_q == w_q - DW'(1)) && (row_q == h_q - DW'(1));
    col_n   = '0;
    row_n   = '0;
    if (state_q == StDraw) begin
      if (col_q == w_q - DW'(1)) begin
        row_n = row_q + DW'(1);
      end else begin
        col_n = col_q + DW'(1);
        row_n = row_q;
      end
    end
    sum_x = {1'b0, x_q} + XSW'(col_n);
    sum_y = {1'b0, y_q} + YSW'(row_n);
    px_on = (32'(sum_x) < XMAX) && (32'(sum_y) < YMAX);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= StIdle;
      last_q       <= IW'(NREQ - 1);
      idx_q        <= '0;
      sel_q        <= '0;
      gnt_q        <= '0;
      done_q       <= '0;
      x_q          <= '0;
      y_q          <= '0;
      w_q          <= '0;
      h_q          <= '0;
      colour_q     <= '0;
      col_q        <= '0;
      row_q        <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_we_q     <= 1'b0;
    end else begin
      gnt_q    <= '0;
      done_q   <= '0;
      vga_we_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            state_q  <= StArb;
            gnt_q    <= pick;
            sel_q    <= pick;
            idx_q    <= pick_idx;
            x_q      <= sel_x;
            y_q      <= sel_y;
            w_q      <= sel_w;
            h_q      <= sel_h;
            colour_q <= sel_c;
          end
        end
        StArb, StDraw: begin
          if ((state_q == StArb && (w_q == '0 || h_q == '0)) ||
              (state_q == StDraw && last_px)) begin
            state_q <= StDone;
            done_q  <= sel_q;
          end else begin
            state_q      <= StDraw;
            col_q        <= col_n;
            row_q        <= row_n;
            vga_x_q      <= sum_x[XW-1:0];
            vga_y_q      <= sum_y[YW-1:0];
            vga_colour_q <= colour_q;
            vga_we_q     <= px_on;
          end
        end
        StDone: begin
          state_q <= StIdle;
          last_q  <= idx_q;
          col_q   <= '0;
          row_q   <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gnt_o        = gnt_q;
  assign done_o       = done_q;
  assign vga_x_o      = vga_x_q;
  assign vga_y_o      = vga_y_q;
  assign vga_colour_o = vga_colour_q;
  assign vga_we_o     = vga_we_q;
  assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_rect_plot_arbiter.sv
// Bench for rect_plot_arbiter: directed rectangle table, round-robin, reset and
// operand-hold sequences, then random traffic against a transaction-level model.
module tb_rect_plot_arbiter;

  localparam int unsigned NREQ = 3;
  localparam int unsigned XW   = 8;
  localparam int unsigned YW   = 7;
  localparam int unsigned CW   = 3;
  localparam int unsigned DW   = 4;
  localparam int          XMAX = 160;
  localparam int          YMAX = 120;

  logic                 clk = 1'b0;
  logic                 resetn;
  logic [NREQ-1:0]      req;
  logic [NREQ*XW-1:0]   req_x;
  logic [NREQ*YW-1:0]   req_y;
  logic [NREQ*DW-1:0]   req_w, req_h;
  logic [NREQ*CW-1:0]   req_colour;
  logic [NREQ-1:0]      gnt, done;
  logic [XW-1:0]        vga_x;
  logic [YW-1:0]        vga_y;
  logic [CW-1:0]        vga_colour;
  logic                 vga_we, busy;

  rect_plot_arbiter #(
    .NREQ (NREQ), .XW (XW), .YW (YW), .CW (CW),
    .XMAX (XMAX), .YMAX (YMAX), .DW (DW)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_i        (req),
    .req_x_i      (req_x),
    .req_y_i      (req_y),
    .req_w_i      (req_w),
    .req_h_i      (req_h),
    .req_colour_i (req_colour),
    .gnt_o        (gnt),
    .done_o       (done),
    .vga_x_o      (vga_x),
    .vga_y_o      (vga_y),
    .vga_colour_o (vga_colour),
    .vga_we_o     (vga_we),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Requester-side state: pending flag and operands per requester.
  logic pend[NREQ];
  int   ox[NREQ], oy[NREQ], ow[NREQ], oh[NREQ], oc[NREQ];

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req[i]                   = pend[i];
      req_x[i*XW +: XW]        = XW'(ox[i]);
      req_y[i*YW +: YW]        = YW'(oy[i]);
      req_w[i*DW +: DW]        = DW'(ow[i]);
      req_h[i*DW +: DW]        = DW'(oh[i]);
      req_colour[i*CW +: CW]   = CW'(oc[i]);
    end
  endtask

  task automatic rand_ops(input int i);
    ox[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(140, 255)) : int'($urandom_range(0, 159));
    oy[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(100, 127)) : int'($urandom_range(0, 119));
    ow[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(8, 15)) : int'($urandom_range(0, 4));
    oh[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(8, 15)) : int'($urandom_range(0, 4));
    oc[i] = int'($urandom_range(0, 7));
  endtask

  function automatic logic [25:0] all_outs();
    return {gnt, done, vga_we, vga_x, vga_y, vga_colour, busy};
  endfunction

  task automatic do_reset(input string name);
    resetn = 1'b0;
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    drive();
    @(negedge clk);
    @(negedge clk);
    check(name, 32'(all_outs()), 32'd0);
    resetn = 1'b1;
  endtask

  typedef struct {
    int idx, x, y, w, h, c;
    bit scramble;
    int exp_we, exp_done, exp_fx, exp_fy, exp_lx, exp_ly;
  } vec_t;

  vec_t vecs[9];

  task automatic run_vec(input vec_t v, input int n);
    int we_cnt, done_at, fx, fy, lx, ly, first_we, bad_c, extra_gnt, k;
    logic [NREQ-1:0] oh_idx;
    we_cnt = 0; done_at = -1; fx = -1; fy = -1; lx = -1; ly = -1;
    first_we = -1; bad_c = 0; extra_gnt = 0;
    oh_idx = NREQ'(1) << v.idx;
    pend[v.idx] = 1'b1;
    ox[v.idx] = v.x; oy[v.idx] = v.y; ow[v.idx] = v.w; oh[v.idx] = v.h; oc[v.idx] = v.c;
    drive();
    @(negedge clk);
    check($sformatf("v%0d gnt", n), 32'(gnt), 32'(oh_idx));
    check($sformatf("v%0d busy_arb", n), 32'(busy), 32'd1);
    pend[v.idx] = 1'b0;
    if (v.scramble) begin
      ox[v.idx] = v.x ^ 3; oy[v.idx] = v.y ^ 5; ow[v.idx] = 9; oh[v.idx] = 9; oc[v.idx] = v.c ^ 7;
    end
    drive();
    k = 2;
    while (done_at < 0 && k < 400) begin
      @(negedge clk);
      if (vga_we) begin
        if (first_we < 0) begin first_we = k; fx = int'(vga_x); fy = int'(vga_y); end
        lx = int'(vga_x); ly = int'(vga_y);
        we_cnt++;
        if (int'(vga_colour) != v.c) bad_c++;
      end
      if (gnt != '0) extra_gnt++;
      if (done != '0) begin
        done_at = k;
        check($sformatf("v%0d done_idx", n), 32'(done), 32'(oh_idx));
        check($sformatf("v%0d busy_done", n), 32'(busy), 32'd1);
      end
      k++;
    end
    check($sformatf("v%0d done_cycle", n), 32'(done_at), 32'(v.exp_done));
    check($sformatf("v%0d we_count", n), 32'(we_cnt), 32'(v.exp_we));
    check($sformatf("v%0d first_we_cycle", n), 32'(first_we), (v.exp_we > 0) ? 32'd2 : 32'hffff_ffff);
    check($sformatf("v%0d first_xy", n), {16'(fx), 16'(fy)}, {16'(v.exp_fx), 16'(v.exp_fy)});
    check($sformatf("v%0d last_xy", n), {16'(lx), 16'(ly)}, {16'(v.exp_lx), 16'(v.exp_ly)});
    check($sformatf("v%0d colour_errs", n), 32'(bad_c), 32'd0);
    check($sformatf("v%0d extra_gnt", n), 32'(extra_gnt), 32'd0);
    @(negedge clk);
    check($sformatf("v%0d idle_after", n), 32'(busy), 32'd0);
  endtask

  typedef struct packed {
    logic [2:0] g;
    logic [2:0] d;
    logic       we;
    logic       busy;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } exp_t;

  exp_t q[$];
  int   grants[$];
  int   pixcnt[$];

  initial begin
    exp_t e;
    int   ml, pk, j, cnt, seen_done, bound;
    bit   was_idle;
    int   exp_order[4];

    vecs[0] = '{0, 10, 20, 3, 2, 4, 1'b0, 6, 8, 10, 20, 12, 21};
    vecs[1] = '{1, 158, 119, 4, 2, 5, 1'b0, 2, 10, 158, 119, 159, 119};
    vecs[2] = '{2, 50, 50, 0, 5, 1, 1'b0, 0, 2, -1, -1, -1, -1};
    vecs[3] = '{0, 10, 20, 3, 2, 4, 1'b1, 6, 8, 10, 20, 12, 21};
    vecs[4] = '{1, 200, 10, 3, 3, 2, 1'b0, 0, 11, -1, -1, -1, -1};
    vecs[5] = '{2, 0, 118, 1, 4, 7, 1'b0, 2, 6, 0, 118, 0, 119};
    vecs[6] = '{0, 255, 5, 2, 1, 3, 1'b0, 0, 4, -1, -1, -1, -1};
    vecs[7] = '{1, 100, 5, 15, 15, 6, 1'b1, 225, 227, 100, 5, 114, 19};
    vecs[8] = '{2, 159, 0, 2, 1, 0, 1'b0, 1, 4, 159, 0, 159, 0};
    exp_order = '{0, 1, 2, 0};

    for (int i = 0; i < NREQ; i++) begin
      ox[i] = 0; oy[i] = 0; ow[i] = 0; oh[i] = 0; oc[i] = 0;
    end
    do_reset("reset_outputs");
    @(negedge clk);
    check("idle_after_reset", 32'(all_outs()), 32'd0);

    for (int n = 0; n < 9; n++) run_vec(vecs[n], n);

    // Round robin from reset: all three held, 1x1 rectangles.
    do_reset("reset_rr");
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b1; ox[i] = 5; oy[i] = 5; ow[i] = 1; oh[i] = 1; oc[i] = i + 1;
    end
    drive();
    cnt = 0; bound = 0;
    while (bound < 60 && (grants.size() < 4 || busy)) begin
      @(negedge clk);
      bound++;
      if (gnt != '0) begin
        if (grants.size() > 0) pixcnt.push_back(cnt);
        cnt = 0;
        for (int i = 0; i < NREQ; i++) if (gnt[i]) grants.push_back(i);
        if (grants.size() == 4) begin
          for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
          drive();
        end
      end
      if (vga_we) begin
        cnt++;
        if (grants.size() > 0)
          check("rr_colour", 32'(vga_colour), 32'(grants[grants.size()-1] + 1));
      end
    end
    pixcnt.push_back(cnt);
    check("rr_grant_count", 32'(grants.size()), 32'd4);
    for (int g = 0; g < 4; g++) begin
      if (g < grants.size()) begin
        check($sformatf("rr_order%0d", g), 32'(grants[g]), 32'(exp_order[g]));
        check($sformatf("rr_pixels%0d", g), 32'(pixcnt[g]), 32'd1);
      end
    end
    check("rr_idle", 32'(busy), 32'd0);

    // Reset on the third pixel of a 4x4 rectangle; the request stays high.
    pend[0] = 1'b1; ox[0] = 30; oy[0] = 40; ow[0] = 4; oh[0] = 4; oc[0] = 3;
    drive();
    cnt = 0; bound = 0;
    while (cnt < 3 && bound < 20) begin
      @(negedge clk);
      bound++;
      if (vga_we) cnt++;
    end
    check("rst_mid_third_px", 32'(cnt), 32'd3);
    resetn = 1'b0;
    @(negedge clk);
    check("rst_mid_outputs", 32'(all_outs()), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    check("rst_restart_gnt", 32'(gnt), 32'd1);
    check("rst_no_done", 32'(done), 32'd0);
    pend[0] = 1'b0;
    drive();
    @(negedge clk);
    check("rst_restart_px", {vga_we, vga_x, vga_y}, {1'b1, 8'd30, 7'd40});
    seen_done = 0; bound = 0;
    while (seen_done == 0 && bound < 40) begin
      @(negedge clk);
      bound++;
      if (done != '0) seen_done = bound;
    end
    check("rst_restart_done_cycle", 32'(seen_done), 32'd16);
    @(negedge clk);

    // Random traffic against the transaction model.
    do_reset("reset_rand");
    ml = NREQ - 1;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(negedge clk);
      was_idle = (q.size() == 0);
      e = was_idle ? '0 : q.pop_front();
      check("rnd_ctl", {gnt, done, vga_we, busy}, {e.g, e.d, e.we, e.busy});
      if (e.we) check("rnd_pix", {vga_x, vga_y, vga_colour}, {e.x, e.y, e.c});
      for (int i = 0; i < NREQ; i++) if (e.g[i]) pend[i] = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i]) begin
          rand_ops(i);
          if ($urandom_range(0, 3) == 0) pend[i] = 1'b1;
        end
      end
      drive();
      if (was_idle && req != '0) begin
        pk = -1;
        for (int k = 1; k <= NREQ; k++) begin
          j = (ml + k) % NREQ;
          if (pk < 0 && pend[j]) pk = j;
        end
        ml = pk;
        e = '0; e.busy = 1'b1; e.g = 3'(1 << pk);
        q.push_back(e);
        for (int r = 0; r < oh[pk]; r++) begin
          for (int c = 0; c < ow[pk]; c++) begin
            e = '0; e.busy = 1'b1;
            e.we = (ox[pk] + c < XMAX) && (oy[pk] + r < YMAX);
            e.x = 8'(ox[pk] + c); e.y = 7'(oy[pk] + r); e.c = 3'(oc[pk]);
            q.push_back(e);
          end
        end
        e = '0; e.busy = 1'b1; e.d = 3'(1 << pk);
        q.push_back(e);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
